piso_serializer: RTL and testbench
==================================

# piso_serializer

Parametrised parallel-in/serial-out serializer for the SerDes transmit path. It replaces the fixed 10-bit load-enable shifter. It accepts words over a valid/ready handshake and buffers one word ahead, so back-to-back frames leave as a gap-free bit stream. Bit order is selectable, and each serial frame can optionally carry an even-parity bit. It sits between the TX encoder/word source and the serial line driver.

## Interface
- `DATA_W`, default 10: parallel word width, ≥ 2.
- `LSB_FIRST`, default 0: 0 sends bit `DATA_W-1` first; 1 sends bit 0 first.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `par_in`  in  `DATA_W`: parallel word. Sampled only on acceptance.
- `par_valid`  in  1: source has a word on `par_in`.
- `par_ready`  out  1: block can take a word. Equals `!hold_full`.
- `ser_out`  out  1: serial data bit, registered.
- `ser_valid`  out  1: `ser_out` carries a frame bit this cycle, registered.
- `frame_start`  out  1: high with the first bit of each frame, registered.

## Operation
- Frame length: `FRAME_W = DATA_W`, or `DATA_W+1` when parity is enabled.
- Acceptance: a word is accepted on any rising edge where `par_valid && par_ready`.
- Storage: one shift register, a one-word hold buffer (`hold_full` flag), and a bit counter `bit_cnt` of width `$clog2(FRAME_W)`.
- FSM states:
  - IDLE: shifter empty, `ser_valid` = 0.
  - SHIFT: shifter emitting bits `0..FRAME_W-1`.
- Shifter load sources, in priority order:
  - the hold buffer, if `hold_full`;
  - otherwise the word being accepted on that edge (bypass).
- Shifter loads happen when:
  - in IDLE; or
  - in SHIFT, on the edge ending the last bit (`bit_cnt == FRAME_W-1`).
- A word accepted while the shifter is busy, and not consumed by a load on the same edge, goes into the hold buffer.
- Simultaneous load from hold and a new acceptance on the same edge: the hold buffer takes the new word and `hold_full` stays 1.
- SHIFT → IDLE happens when the last bit ends and no word is available.
- Load edge outputs: `bit_cnt` ← 0, `ser_valid` ← 1, `frame_start` ← 1.
- `ser_out` presents word bits in the order set by `LSB_FIRST`. With parity, the parity bit follows as the final bit.
- Idle outputs: `ser_out` = 0, `ser_valid` = 0, `frame_start` = 0.
- `par_in` must not be used after the acceptance edge.

## Timing
- Reset values:
  - `ser_out` 0, `ser_valid` 0, `frame_start` 0.
  - `hold_full` 0, so `par_ready` reads 1.
  - FSM in IDLE, `bit_cnt` 0.
  - No acceptance occurs while `rst_n` is low.
- Latency: a word accepted at edge E into an idle block puts its first bit on `ser_out` in the cycle after E. The last bit occupies cycle E+`FRAME_W`.
- Throughput: with `par_valid` held high, frames are contiguous: `ser_valid` stays 1 and `frame_start` pulses every `FRAME_W` cycles.
- Backpressure: `par_ready` falls in the cycle after a word lands in the hold buffer. It rises in the cycle after the hold buffer drains into the shifter.
- Reset mid-frame: all outputs clear immediately (asynchronously). The in-flight word and the held word are discarded. After `rst_n` rises, the first rising edge may accept.

## Configuration
- `SERDES_PARITY_EN` defined:
  - `FRAME_W = DATA_W+1`.
  - The last bit is the even parity of the word, `^word`.
  - `frame_start` pulses every `DATA_W+1` cycles in a continuous stream.
- `SERDES_PARITY_EN` undefined:
  - `FRAME_W = DATA_W`.
  - No parity logic is instantiated.

## Structure
- Package `serdes_pkg`:
  - default `DATA_W` constant (10);
  - `piso_state_t` enum (IDLE, SHIFT);
  - a function computing `FRAME_W` from `DATA_W`, conditioned on `SERDES_PARITY_EN`.
- Sub-module `serdes_hold_buf`: the one-word buffer with `hold_full`, write-on-accept and read-on-load ports, and simultaneous read/write support.
- The shifter, counter and FSM stay in `piso_serializer`.

## Test plan
- MSB-first single word: reset, then accept 10'b1010101010 → `ser_out` 1,0,1,0,1,0,1,0,1,0 in consecutive cycles. `frame_start` is high on the first bit only, then `ser_valid` drops.
- `LSB_FIRST=1`: same word → `ser_out` 0,1,0,1,0,1,0,1,0,1.
- Back-to-back frames: `par_valid` held high with 10'h3FF then 10'h000 → 20 contiguous `ser_valid` cycles (ten 1s then ten 0s), `frame_start` at bits 0 and 10, no gap.
- Backpressure: three words offered continuously → `par_ready` drops after the second acceptance. The third word is accepted only after the hold buffer drains. All 30 bits are in order.
- Parity, `SERDES_PARITY_EN` defined: accept 10'b0000000111 → 11-bit frame with final bit 1. 10'b0000000011 → final bit 0.
- Reset mid-frame: assert `rst_n`=0 during bit 4 → `ser_out`, `ser_valid`, `frame_start` go to 0 immediately and `par_ready` reads 1. After release, a new word serializes cleanly with no residue of the old one.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared constants, FSM type and frame-length helper for the SerDes TX serializer.
// Define SERDES_PARITY_EN to append an even-parity bit to every frame.
package serdes_pkg;

  localparam int unsigned DefaultDataW = 10;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } piso_state_t;

  function automatic int unsigned frame_w(input int unsigned data_w);
`ifdef SERDES_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/serdes_hold_buf.sv
// One-word skid buffer in front of the serializer's shifter.
// A write and a read on the same edge leave the buffer full with the new word.
module serdes_hold_buf
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    full_d = full_q;
    if (wr_en) begin
      full_d = 1'b1;
    end else if (rd_en) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      if (wr_en) begin
        data_q <= wr_data;
      end
    end
  end

  assign rd_data = data_q;
  assign full    = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input and one-word hold buffer.
// Define SERDES_PARITY_EN to append even parity (^word) as the last bit of each frame.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] par_in,
  input  logic              par_valid,
  output logic              par_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start
);

  localparam int unsigned     FrameW  = frame_w(DATA_W);
  localparam int unsigned     CntW    = $clog2(FrameW);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameW - 1);

  piso_state_t       state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [FrameW-1:0] shift_q;
  logic [FrameW-1:0] frame;
  logic              ser_out_q, ser_valid_q, frame_start_q;

  logic              hold_full, hold_wr, hold_rd;
  logic [DATA_W-1:0] hold_data, load_word, ordered;
  logic              accept, load_slot, do_load, bypass;

  assign par_ready = !hold_full;
  assign accept    = par_valid && par_ready;
  assign load_slot = (state_q == StIdle) || (bit_cnt_q == LastCnt);
  assign do_load   = load_slot && (hold_full || accept);
  // An accepted word skips the buffer only when it goes straight into the shifter.
  assign bypass    = do_load && !hold_full;
  assign hold_wr   = accept && !bypass;
  assign hold_rd   = do_load && hold_full;
  assign load_word = hold_full ? hold_data : par_in;

  serdes_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (hold_wr),
    .wr_data (par_in),
    .rd_en   (hold_rd),
    .rd_data (hold_data),
    .full    (hold_full)
  );

  // Frame is laid out in emission order: bit 0 leaves first.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ordered[i] = LSB_FIRST ? load_word[i] : load_word[DATA_W-1-i];
    end
`ifdef SERDES_PARITY_EN
    frame = {^load_word, ordered};
`else
    frame = ordered;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (do_load) begin
      state_q       <= StShift;
      bit_cnt_q     <= '0;
      ser_out_q     <= frame[0];
      shift_q       <= frame >> 1;
      ser_valid_q   <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        StShift: begin
          if (bit_cnt_q == LastCnt) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            ser_out_q <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end
        end
        default: begin
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus and are
// checked every cycle against a bit-stream queue model; honours SERDES_PARITY_EN.
module tb_piso_serializer;

  localparam int unsigned DW = 10;
`ifdef SERDES_PARITY_EN
  localparam int unsigned FW = DW + 1;
`else
  localparam int unsigned FW = DW;
`endif

  typedef struct packed {
    logic b;
    logic first;
  } sbit_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          par_valid = 1'b0;
  logic [DW-1:0] par_in = '0;
  logic          m_ready, m_out, m_valid, m_start;
  logic          l_ready, l_out, l_valid, l_start;

  piso_serializer #(
    .DATA_W    (DW),
    .LSB_FIRST (1'b0)
  ) dut_msb (
    .clk         (clk),
    .rst_n       (rst_n),
    .par_in      (par_in),
    .par_valid   (par_valid),
    .par_ready   (m_ready),
    .ser_out     (m_out),
    .ser_valid   (m_valid),
    .frame_start (m_start)
  );

  piso_serializer #(
    .DATA_W    (DW),
    .LSB_FIRST (1'b1)
  ) dut_lsb (
    .clk         (clk),
    .rst_n       (rst_n),
    .par_in      (par_in),
    .par_valid   (par_valid),
    .par_ready   (l_ready),
    .ser_out     (l_out),
    .ser_valid   (l_valid),
    .frame_start (l_start)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  sbit_t qm[$];
  sbit_t ql[$];
  sbit_t cur_m, cur_l;
  logic  cur_v;
  logic  exp_ready;

  // Reference: every accepted frame is appended to an outgoing bit stream; one bit leaves
  // per cycle starting the cycle after acceptance. A whole frame still queued means the
  // single buffer is occupied, so ready is low.
  function automatic logic [7:0] expected();
    return {cur_v & cur_m.b, cur_v, cur_v & cur_m.first, exp_ready,
            cur_v & cur_l.b, cur_v, cur_v & cur_l.first, exp_ready};
  endfunction

  function automatic logic [7:0] observed();
    return {m_out, m_valid, m_start, m_ready, l_out, l_valid, l_start, l_ready};
  endfunction

  task automatic model_reset();
    qm.delete();
    ql.delete();
    cur_v     = 1'b0;
    cur_m     = '0;
    cur_l     = '0;
    exp_ready = 1'b1;
  endtask

  task automatic model_edge(input logic acc, input logic [DW-1:0] w);
    if (acc) begin
      for (int i = 0; i < DW; i++) begin
        qm.push_back('{b: w[DW-1-i], first: (i == 0)});
        ql.push_back('{b: w[i], first: (i == 0)});
      end
`ifdef SERDES_PARITY_EN
      qm.push_back('{b: ^w, first: 1'b0});
      ql.push_back('{b: ^w, first: 1'b0});
`endif
    end
    cur_v = (qm.size() > 0);
    if (cur_v) begin
      cur_m = qm.pop_front();
      cur_l = ql.pop_front();
    end else begin
      cur_m = '0;
      cur_l = '0;
    end
    exp_ready = (qm.size() < int'(FW));
  endtask

  task automatic tick(input logic acc, input logic [DW-1:0] w);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(acc, w);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    par_valid = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (observed() !== 8'b0001_0001) begin
        n_err++;
        $display("FAIL reset cyc %0d: got %b want %b", i, observed(), 8'b0001_0001);
      end
      tick(1'b0, par_in);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    logic [DW-1:0] got_m, got_l, want_m, want_l;
    int nb;
    want_m = 10'b1010101010;
    want_l = 10'b0101010101;
    got_m  = '0;
    got_l  = '0;
    nb     = 0;
    for (int i = 0; i < int'(FW) + 4; i++) begin
      par_valid = (i == 0);
      par_in    = 10'b1010101010;
      @(negedge clk);
      n_vec++;
      if (observed() !== expected()) begin
        n_err++;
        $display("FAIL single cyc %0d: got %b want %b", i, observed(), expected());
      end
      if (m_valid && nb < int'(DW)) begin
        got_m = {got_m[DW-2:0], m_out};
        got_l = {got_l[DW-2:0], l_out};
        nb++;
      end
      tick(par_valid && exp_ready, par_in);
    end
    n_vec++;
    if ({got_m, got_l} !== {want_m, want_l}) begin
      n_err++;
      $display("FAIL single_bits: got %b/%b want %b/%b", got_m, got_l, want_m, want_l);
    end
  endtask

  task automatic test_back_to_back();
    int first_v, last_v, nv, ns;
    first_v = -1;
    last_v  = -1;
    nv      = 0;
    ns      = 0;
    for (int i = 0; i < 2 * int'(FW) + 6; i++) begin
      par_valid = (i < 2);
      par_in    = (i == 0) ? 10'h3FF : 10'h000;
      @(negedge clk);
      n_vec++;
      if (observed() !== expected()) begin
        n_err++;
        $display("FAIL b2b cyc %0d: got %b want %b", i, observed(), expected());
      end
      if (m_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        nv++;
        if (m_start) ns++;
      end
      tick(par_valid && exp_ready, par_in);
    end
    n_vec++;
    if (nv != 2 * int'(FW) || (last_v - first_v + 1) != nv || ns != 2) begin
      n_err++;
      $display("FAIL b2b_stream: got valid=%0d span=%0d starts=%0d want %0d/%0d/2",
               nv, last_v - first_v + 1, ns, 2 * FW, 2 * FW);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] words[3];
    int k;
    logic saw_low;
    for (int j = 0; j < 3; j++) words[j] = DW'($urandom);
    k       = 0;
    saw_low = 1'b0;
    for (int i = 0; i < 3 * int'(FW) + 6; i++) begin
      par_valid = (k < 3);
      par_in    = words[k % 3];
      @(negedge clk);
      n_vec++;
      if (observed() !== expected()) begin
        n_err++;
        $display("FAIL backpressure cyc %0d: got %b want %b", i, observed(), expected());
      end
      if (!m_ready) saw_low = 1'b1;
      if (par_valid && exp_ready) begin
        tick(1'b1, par_in);
        k++;
      end else begin
        tick(1'b0, par_in);
      end
    end
    n_vec++;
    if (saw_low !== 1'b1 || k != 3) begin
      n_err++;
      $display("FAIL backpressure_ready: got low_seen=%b accepted=%0d want 1/3", saw_low, k);
    end
  endtask

`ifdef SERDES_PARITY_EN
  task automatic test_parity();
    for (int i = 0; i < 2 * int'(FW) + 8; i++) begin
      par_valid = (i == 0) || (i == int'(FW) + 3);
      par_in    = (i == 0) ? 10'b0000000111 : 10'b0000000011;
      @(negedge clk);
      n_vec++;
      if (observed() !== expected()) begin
        n_err++;
        $display("FAIL parity cyc %0d: got %b want %b", i, observed(), expected());
      end
      tick(par_valid && exp_ready, par_in);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [DW-1:0] w;
    w = DW'($urandom);
    for (int i = 0; i < 5; i++) begin
      par_valid = (i == 0);
      par_in    = w;
      @(negedge clk);
      n_vec++;
      if (observed() !== expected()) begin
        n_err++;
        $display("FAIL midreset_pre cyc %0d: got %b want %b", i, observed(), expected());
      end
      tick(par_valid && exp_ready, par_in);
    end
    par_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (observed() !== 8'b0001_0001) begin
      n_err++;
      $display("FAIL midreset_async: got %b want %b", observed(), 8'b0001_0001);
    end
    model_reset();
    tick(1'b0, par_in);
    rst_n = 1'b1;
    w = ~w;
    for (int i = 0; i < int'(FW) + 4; i++) begin
      par_valid = (i == 0);
      par_in    = w;
      @(negedge clk);
      n_vec++;
      if (observed() !== expected()) begin
        n_err++;
        $display("FAIL midreset_post cyc %0d: got %b want %b", i, observed(), expected());
      end
      tick(par_valid && exp_ready, par_in);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      par_valid = (i < 380) && ($urandom_range(0, 99) < 65);
      par_in    = DW'($urandom);
      @(negedge clk);
      n_vec++;
      if (observed() !== expected()) begin
        n_err++;
        $display("FAIL random cyc %0d: got %b want %b", i, observed(), expected());
      end
      tick(par_valid && exp_ready, par_in);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
`ifdef SERDES_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
